sap1_load_run_seq: RTL and testbench

- Front-panel sequencer for the SAP-1 CPU. It accepts a program as a byte stream over a valid/ready handshake and writes it into the 16x8 program RAM.
- While loading, it holds the CPU controller (ring counter plus control-word decoder) in reset. It then releases the controller to run, and detects halt.
- It sits between the host/loader interface and the SAP-1 core. It owns the RAM write port during load and the CPU reset line at all times.

---
 rtl/sap1_load_run_seq.sv | 172 +++++++++++++++++
 tb/tb_sap1_load_run_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_load_run_seq.sv
// SAP-1 front-panel sequencer: streams a program into RAM, holds the controller in reset while
// loading, then runs it and waits for halt. Optional run watchdog: SAP1_RUN_WATCHDOG_EN.
module sap1_load_run_seq #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WDOG_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              clear,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   byte_count,
  output logic [15:0]       run_cycles,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StArmed  = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StHalted = 3'd4;
  localparam logic [2:0] StError  = 3'd5;

  localparam logic [ADDR_W-1:0] AddrMax = '1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [15:0]       run_cycles_q, run_cycles_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              accept;

`ifdef SAP1_RUN_WATCHDOG_EN
  localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  assign load_ready = ((state_q == StIdle) || (state_q == StLoad)) && !start;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    byte_count_d = byte_count_q;
    run_cycles_d = run_cycles_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
`ifdef SAP1_RUN_WATCHDOG_EN
    wdog_d       = wdog_q;
`endif

    // Accepted bytes are written one cycle later from the output registers.
    if (accept) begin
      ram_we_d     = 1'b1;
      ram_addr_d   = wptr_q;
      ram_wdata_d  = load_data;
      byte_count_d = byte_count_q + 1'b1;
      if (wptr_q != AddrMax) begin
        wptr_d = wptr_q + 1'b1;
      end
    end

    case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          state_d = (load_last || (wptr_q == AddrMax)) ? StArmed : StLoad;
        end else if ((state_q == StLoad) && start) begin
          state_d = StError;
        end
      end
      StArmed: begin
        if (start) begin
          state_d      = StRun;
          run_cycles_d = '0;
`ifdef SAP1_RUN_WATCHDOG_EN
          wdog_d       = '0;
`endif
        end
      end
      StRun: begin
        if (cpu_halt) begin
          state_d = StHalted;
        end else begin
          if (run_cycles_q != 16'hFFFF) begin
            run_cycles_d = run_cycles_q + 16'd1;
          end
`ifdef SAP1_RUN_WATCHDOG_EN
          if (wdog_q == WdogLast) begin
            state_d = StError;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
`endif
        end
      end
      StHalted, StError: begin
        if (clear) begin
          state_d      = StIdle;
          byte_count_d = '0;
          wptr_d       = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The controller runs only in RUN and stays out of reset in HALTED to keep its output.
    cpu_rst_d = !((state_d == StRun) || (state_d == StHalted));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      byte_count_q <= '0;
      run_cycles_q <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      byte_count_q <= byte_count_d;
      run_cycles_q <= run_cycles_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

`ifdef SAP1_RUN_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign state      = state_q;
  assign byte_count = byte_count_q;
  assign run_cycles = run_cycles_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = (state_q == StHalted);
  assign err        = (state_q == StError);

endmodule

// File: tb/tb_sap1_load_run_seq.sv
// Bench for sap1_load_run_seq: RAM writes are checked against a scoreboard of accepted bytes.
module tb_sap1_load_run_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_last, load_ready;
  logic [7:0] load_data;
  logic       start, clear, cpu_halt;
  logic       ram_we, cpu_rst, done, err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [2:0] state;
  logic [4:0] byte_count;
  logic [15:0] run_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  exp_ptr = 4'd0;

  sap1_load_run_seq #(
    .ADDR_W(4),
    .DATA_W(8),
    .WDOG_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .start(start),
    .clear(clear),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_rst(cpu_rst),
    .cpu_halt(cpu_halt),
    .state(state),
    .byte_count(byte_count),
    .run_cycles(run_cycles),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; byte is accepted on the following posedge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge clk);
    check_eq("load_ready_send", 32'(load_ready), 32'd1);
    exp_q.push_back({exp_ptr, d});
    exp_ptr = exp_ptr + 4'd1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Every write strobe must match the oldest accepted byte.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq("ram_addr", 32'(ram_addr), 32'(e[11:8]));
        check_eq("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'($urandom); load_data = 8'($urandom); load_last = 1'($urandom);
      start = 1'($urandom); clear = 1'($urandom); cpu_halt = 1'($urandom);
      step();
    end
    load_valid = 0; load_data = 0; load_last = 0; start = 0; clear = 0; cpu_halt = 0;
    step();
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_byte_count", 32'(byte_count), 32'd0);
    check_eq("rst_run_cycles", 32'(run_cycles), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_load_ready", 32'(load_ready), 32'd1);
    rst = 1'b1;
    step();

    // Short load
    send_byte(8'h09, 1'b0);
    send_byte(8'h1A, 1'b0);
    send_byte(8'hE0, 1'b1);
    @(negedge clk);
    check_eq("short_state", 32'(state), 32'd2);
    check_eq("short_byte_count", 32'(byte_count), 32'd3);
    check_eq("short_load_ready", 32'(load_ready), 32'd0);

    // Run for 20 cycles, then halt; start/load_valid must be ignored in RUN
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check_eq("run_state", 32'(state), 32'd3);
    check_eq("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("run_cycles_entry", 32'(run_cycles), 32'd0);
    start = 1'b1;
    load_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    load_valid = 1'b0;
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    @(negedge clk);
    check_eq("halt_state", 32'(state), 32'd4);
    check_eq("halt_done", 32'(done), 32'd1);
    check_eq("halt_run_cycles", 32'(run_cycles), 32'd20);
    check_eq("halt_cpu_rst", 32'(cpu_rst), 32'd0);
    step();
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    exp_ptr = 4'd0;
    @(negedge clk);
    check_eq("clear_state", 32'(state), 32'd0);
    check_eq("clear_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("clear_done", 32'(done), 32'd0);
    check_eq("clear_byte_count", 32'(byte_count), 32'd0);

    // Full load auto-arms; a 17th byte is stalled
    step();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    check_eq("full_state", 32'(state), 32'd2);
    check_eq("full_byte_count", 32'(byte_count), 32'd16);
    step();
    load_valid = 1'b1;
    load_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_ready", 32'(load_ready), 32'd0);
      step();
    end
    load_valid = 1'b0;
    @(negedge clk);
    check_eq("stall_state", 32'(state), 32'd2);
    check_eq("stall_byte_count", 32'(byte_count), 32'd16);

    // Reset in the middle of RUN
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_eq("midrun_state", 32'(state), 32'd3);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_ptr = 4'd0;
    @(negedge clk);
    check_eq("midrst_state", 32'(state), 32'd0);
    check_eq("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("midrst_byte_count", 32'(byte_count), 32'd0);
    check_eq("midrst_run_cycles", 32'(run_cycles), 32'd0);

    // Abort: start during LOAD, with a byte offered in the same cycle
    step();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'hCC;
    start      = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(load_ready), 32'd0);
    step();
    start = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_state", 32'(state), 32'd5);
    check_eq("abort_err", 32'(err), 32'd1);
    check_eq("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_ptr = 4'd0;
    @(negedge clk);
    check_eq("abort_clear_state", 32'(state), 32'd0);
    check_eq("abort_clear_err", 32'(err), 32'd0);
    check_eq("abort_clear_byte_count", 32'(byte_count), 32'd0);

    // Watchdog boundary: 49 RUN cycles still running, 50th decides
    step();
    send_byte(8'hF0, 1'b1);
    @(negedge clk);
    check_eq("wd_armed", 32'(state), 32'd2);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("wd_49_state", 32'(state), 32'd3);
    step();
    @(negedge clk);
`ifdef SAP1_RUN_WATCHDOG_EN
    check_eq("wd_50_state", 32'(state), 32'd5);
    check_eq("wd_50_err", 32'(err), 32'd1);
    check_eq("wd_50_cpu_rst", 32'(cpu_rst), 32'd1);
`else
    check_eq("wd_50_state", 32'(state), 32'd3);
    check_eq("wd_50_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("wd_50_run_cycles", 32'(run_cycles), 32'd50);
`endif
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("final_state", 32'(state), 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
